polyphase_mac_sched: RTL
========================

Name: polyphase_mac_sched

Overview:
Control sequencer for the decimate-by-DECIM polyphase IIR section.
- Counts input phases and issues the block-load strobe to the input downsampler register bank.
- Then time-shares one MAC across all branch/tap products (DECIM×NTAPS cycles) and flags each finished output sample.
- Sits between the sample-rate front end and the shared MAC/coefficient ROM.

Parameters:
DECIM, 3, decimation factor / number of polyphase branches (≥2)
NTAPS, 4, coefficient taps per branch (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  soft enable; low freezes phase counting, a run in progress completes
in_valid  in  1  one input sample present this cycle
clr_overrun  in  1  clears sticky overrun
load  out  1  one-cycle strobe: downsampler captures a full DECIM-sample block
phase  out  $clog2(DECIM)  current input phase 0..DECIM-1
busy  out  1  FSM not IDLE
branch_sel  out  $clog2(DECIM)  branch operand select
tap_idx  out  $clog2(NTAPS)  tap operand select
coef_addr  out  $clog2(DECIM*NTAPS)  = branch_sel*NTAPS + tap_idx
mac_clr  out  1  clear accumulator (first product of a run)
mac_en  out  1  accumulate this cycle
out_valid  out  1  one-cycle strobe: accumulator holds the finished output
overrun  out  1  sticky: load arrived with a pending request already queued

Behaviour:
- Reset (async assert, sync release): phase=0, load=0, FSM=IDLE, branch_sel=0, tap_idx=0, coef_addr=0, mac_clr=0, mac_en=0, out_valid=0, pending=0, overrun=0, busy=0.
- Phase counter:
  - advances on in_valid&&enable.
  - wraps DECIM-1→0.
  - At that wrap edge, load<=1 for exactly one cycle.
  - in_valid with enable low is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE: load=1 → RUN, with branch_sel=0 and tap_idx=0.
- RUN:
  - mac_en=1 every cycle; mac_clr=1 only when branch_sel=0 and tap_idx=0.
  - tap_idx increments; on NTAPS-1 it wraps to 0 and branch_sel increments.
  - Exactly DECIM*NTAPS cycles, then → DONE.
- DONE: one cycle, out_valid=1, mac_en=0. Next state:
  - pending=1 → RUN, pending<=load.
  - pending=0, load=1 → RUN.
  - Otherwise → IDLE.
- load while RUN or DONE-without-entry:
  - pending=0 → pending<=1.
  - pending=1 → overrun<=1 and the load is dropped.
- Overrun clearing: clr_overrun clears overrun. A simultaneous new overrun wins (flag stays 1).
- Latency:
  - in_valid of phase DECIM-1 sampled at edge E0.
  - load high in the cycle after E0.
  - First RUN cycle starts after E1.
  - out_valid follows DECIM*NTAPS+2 cycles after E0 (defaults: 14).
- All outputs are registered. coef_addr is registered with branch_sel/tap_idx, with no extra delay.
- Reset mid-run aborts immediately. No out_valid is issued for the aborted run.

Optional Feature:
Macro PHASE_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit).
  - sync=1 synchronously forces phase=0, FSM=IDLE, pending=0, load=0, mac_en=0, out_valid=0.
  - overrun is unaffected.
  - sync has priority over in_valid in the same cycle (that sample is counted as nothing).
- Undefined: no sync port; the phase is aligned only by reset.

Decomposition:
- Shared package filter_pkg holds:
  - DECIM_DEF and NTAPS_DEF constants.
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sched_state_t.
  - Width helper localparams for phase, tap and addr.
- One natural sub-module: mod_cnt (parameterised modulo-N counter with enable, wrap strobe and synchronous clear). It is instantiated for the phase counter, tap_idx and branch_sel.

Test Plan:
1. Defaults, in_valid every cycle from reset release:
   - load pulses every 3rd cycle.
   - phase sequence 0,1,2,0.
   - After the first load, coef_addr runs 0..11 with mac_en=1, mac_clr only at addr 0.
   - out_valid at cycle E0+14; overrun stays 0 only if in_valid spacing ≥5 cycles (check both rates).
2. in_valid every cycle continuously:
   - Loads every 3 cycles against runs of 14 → pending then overrun=1 by the third block.
   - clr_overrun pulse with a coincident overrun event leaves overrun=1.
3. in_valid every 5th cycle (block every 15):
   - Back-to-back runs via DONE→RUN with a one-cycle out_valid gap.
   - pending never causes overrun.
4. enable low during phase=1 for 10 cycles with in_valid high:
   - phase holds at 1.
   - Active run finishes and out_valid is still issued.
5. reset asserted at RUN coef_addr=6:
   - All outputs 0 immediately (asynchronous).
   - No out_valid; after release, phase restarts at 0.
6. PHASE_SYNC_EN defined, sync pulse at phase=2 with in_valid=1:
   - No load; phase=0 next cycle.
   - A run in progress aborts with mac_en=0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants, scheduler state type and width helpers for the polyphase MAC scheduler.
package filter_pkg;

  localparam int DECIM_DEF = 3;
  localparam int NTAPS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  // Counter width that never collapses to zero bits for N == 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PHASE_W_DEF = cnt_width(DECIM_DEF);
  localparam int TAP_W_DEF   = cnt_width(NTAPS_DEF);
  localparam int ADDR_W_DEF  = cnt_width(DECIM_DEF * NTAPS_DEF);

endpackage

// File: rtl/mod_cnt.sv
// Modulo-N counter with count enable, wrap strobe and synchronous clear.
module mod_cnt #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == W'(N - 1));
  assign o_cnt  = r_cnt;

  // Count state; clear dominates enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (o_wrap) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/polyphase_mac_sched.sv
// Polyphase decimator scheduler: input phase counting, block load and shared-MAC sequencing.
// Build option PHASE_SYNC_EN adds a synchronous phase-alignment input 'sync'.
module polyphase_mac_sched
  import filter_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int NTAPS = NTAPS_DEF,
  localparam int PW = cnt_width(DECIM),
  localparam int TW = cnt_width(NTAPS),
  localparam int AW = cnt_width(DECIM * NTAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          in_valid,
  input  logic          clr_overrun,
`ifdef PHASE_SYNC_EN
  input  logic          sync,
`endif
  output logic          load,
  output logic [PW-1:0] phase,
  output logic          busy,
  output logic [PW-1:0] branch_sel,
  output logic [TW-1:0] tap_idx,
  output logic [AW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          out_valid,
  output logic          overrun
);

  sched_state_t  r_state;
  logic          r_pending;
  logic          r_load;
  logic          r_mac_en;
  logic          r_mac_clr;
  logic          r_out_valid;
  logic          r_overrun;
  logic          r_busy;
  logic [AW-1:0] r_coef_addr;

  logic          w_sync;
  logic          w_phase_wrap;
  logic          w_run_step;
  logic          w_tap_wrap;
  logic          w_branch_wrap;
  logic [PW-1:0] w_phase;
  logic [PW-1:0] w_branch;
  logic [TW-1:0] w_tap;

`ifdef PHASE_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_run_step = (r_state == S_RUN) && !w_sync;

  mod_cnt #(.N(DECIM), .W(PW)) u_phase_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_sync),
    .i_en   (in_valid && enable),
    .o_cnt  (w_phase),
    .o_wrap (w_phase_wrap)
  );

  mod_cnt #(.N(NTAPS), .W(TW)) u_tap_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_sync),
    .i_en   (w_run_step),
    .o_cnt  (w_tap),
    .o_wrap (w_tap_wrap)
  );

  // Branch wrap marks the last product of a run
  mod_cnt #(.N(DECIM), .W(PW)) u_branch_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_sync),
    .i_en   (w_tap_wrap),
    .o_cnt  (w_branch),
    .o_wrap (w_branch_wrap)
  );

  // Linear coefficient address, stepped on the same edges as tap/branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coef_addr <= {AW{1'b0}};
    end else if (w_sync || w_branch_wrap) begin
      r_coef_addr <= {AW{1'b0}};
    end else if (w_run_step) begin
      r_coef_addr <= r_coef_addr + AW'(1);
    end else begin
      r_coef_addr <= r_coef_addr;
    end
  end

  // Scheduler FSM with registered strobes; one queued block may wait behind a run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_load      <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (clr_overrun) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
      if (w_sync) begin
        r_state     <= S_IDLE;
        r_pending   <= 1'b0;
        r_load      <= 1'b0;
        r_mac_en    <= 1'b0;
        r_mac_clr   <= 1'b0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        r_load <= w_phase_wrap;
        case (r_state)
          S_IDLE: begin
            r_out_valid <= 1'b0;
            if (r_load) begin
              r_state   <= S_RUN;
              r_mac_en  <= 1'b1;
              r_mac_clr <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_mac_en  <= 1'b0;
              r_mac_clr <= 1'b0;
              r_busy    <= 1'b0;
            end
          end
          S_RUN: begin
            r_mac_clr <= 1'b0;
            r_busy    <= 1'b1;
            if (r_load && r_pending) begin
              r_overrun <= 1'b1;
            end else if (r_load) begin
              r_pending <= 1'b1;
            end else begin
              r_pending <= r_pending;
            end
            if (w_branch_wrap) begin
              r_state     <= S_DONE;
              r_mac_en    <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_mac_en    <= 1'b1;
              r_out_valid <= 1'b0;
            end
          end
          S_DONE: begin
            r_out_valid <= 1'b0;
            if (r_pending || r_load) begin
              r_state   <= S_RUN;
              r_mac_en  <= 1'b1;
              r_mac_clr <= 1'b1;
              r_busy    <= 1'b1;
              r_pending <= r_pending && r_load;
            end else begin
              r_state   <= S_IDLE;
              r_mac_en  <= 1'b0;
              r_mac_clr <= 1'b0;
              r_busy    <= 1'b0;
              r_pending <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign load       = r_load;
  assign phase      = w_phase;
  assign busy       = r_busy;
  assign branch_sel = w_branch;
  assign tap_idx    = w_tap;
  assign coef_addr  = r_coef_addr;
  assign mac_clr    = r_mac_clr;
  assign mac_en     = r_mac_en;
  assign out_valid  = r_out_valid;
  assign overrun    = r_overrun;

endmodule
